cn_apb_sequencer: RTL and testbench

//  Per-completer-node controller. Round-robin arbitrates the 3 RN request channels and drives the
//  cn_crossbar select. Sequences the APB SETUP/ACCESS phases, captures the completion, and returns
//  a one-cycle cn_ready pulse to the granted RN. Replaces the stateless arbitrator inside complete_node.

---
 rtl/cn_pkg.sv | 31 +++
 rtl/cn_rr_pick.sv | 27 ++
 rtl/cn_apb_sequencer.sv | 129 ++++++++++++
 tb/tb_cn_apb_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cn_pkg.sv
// Shared types and constants for the completer-node APB sequencer and its round-robin picker.
package cn_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} cn_state_t;

  localparam int N_RN           = 3;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int TO_CNT_W       = 5;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_RN1  = 2'b01;
  localparam logic [1:0] SEL_RN2  = 2'b10;
  localparam logic [1:0] SEL_RN3  = 2'b11;

  function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

  function automatic logic [2:0] sel_to_onehot(input logic [1:0] sel);
    logic [2:0] oh;
    oh = 3'b000;
    case (sel)
      SEL_RN1: oh = 3'b001;
      SEL_RN2: oh = 3'b010;
      SEL_RN3: oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/cn_rr_pick.sv
// Combinational round-robin pick over 3 requesters, searching last+1, last+2, last (mod 3).
// Zero latency; no flow control of its own.
module cn_rr_pick
  import cn_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt_sel,
  output logic       any
);

  logic [1:0] last_idx;
  logic [1:0] idx;

  always_comb begin
    last_idx = (last == SEL_NONE) ? 2'd2 : last - 2'd1;
    gnt_sel  = SEL_NONE;
    idx      = 2'd0;
    // Walk from lowest to highest priority so the highest-priority hit is written last.
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((int'(last_idx) + k) % 3);
      if (req[idx]) gnt_sel = idx_to_sel(idx);
    end
    any = |req;
  end

endmodule

// File: rtl/cn_apb_sequencer.sv
// Completer-node controller: round-robin grant, APB SETUP/ACCESS sequencing, one-cycle cn_ready pulse.
// Min 4 cycles request to response, 5 between grants; optional ACCESS abort under CN_TIMEOUT_EN.
module cn_apb_sequencer
  import cn_pkg::*;
(
  input  logic            pclk,
  input  logic            preset_n,
  input  logic [N_RN-1:0] rn_valid,
  output logic [N_RN-1:0] cn_ready,
  output logic [1:0]      crossbar_sel,
  output logic            psel,
  output logic            penable,
  input  logic            pready,
  input  logic            pslverr,
  output logic            rsp_err,
  output logic            timeout_pulse
);

  cn_state_t       state_q, state_d;
  logic [1:0]      crossbar_sel_q, crossbar_sel_d;
  logic [1:0]      last_grant_q, last_grant_d;
  logic [N_RN-1:0] cn_ready_q, cn_ready_d;
  logic            rsp_err_q, rsp_err_d;
  logic [1:0]      pick_sel;
  logic            pick_any;

`ifdef CN_TIMEOUT_EN
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic                timeout_pulse_q, timeout_pulse_d;
`endif

  cn_rr_pick u_pick (
    .req     (rn_valid),
    .last    (last_grant_q),
    .gnt_sel (pick_sel),
    .any     (pick_any)
  );

  always_comb begin
    state_d        = state_q;
    crossbar_sel_d = crossbar_sel_q;
    last_grant_d   = last_grant_q;
    cn_ready_d     = '0;
    rsp_err_d      = rsp_err_q;
`ifdef CN_TIMEOUT_EN
    to_cnt_d        = to_cnt_q;
    timeout_pulse_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // The granted RN still shows rn_valid during its cn_ready cycle, so skip arbitration then.
        if (cn_ready_q != '0) begin
          crossbar_sel_d = SEL_NONE;
          rsp_err_d      = 1'b0;
        end else if (pick_any) begin
          crossbar_sel_d = pick_sel;
          last_grant_d   = pick_sel;
          state_d        = SETUP;
        end else begin
          crossbar_sel_d = SEL_NONE;
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef CN_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          rsp_err_d = pslverr;
          state_d   = RESP;
        end
`ifdef CN_TIMEOUT_EN
        else if (to_cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_err_d       = 1'b1;
          timeout_pulse_d = 1'b1;
          state_d         = RESP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        cn_ready_d = sel_to_onehot(crossbar_sel_q);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q        <= IDLE;
      crossbar_sel_q <= SEL_NONE;
      last_grant_q   <= SEL_RN3;
      cn_ready_q     <= '0;
      rsp_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      crossbar_sel_q <= crossbar_sel_d;
      last_grant_q   <= last_grant_d;
      cn_ready_q     <= cn_ready_d;
      rsp_err_q      <= rsp_err_d;
    end
  end

`ifdef CN_TIMEOUT_EN
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      to_cnt_q        <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      to_cnt_q        <= to_cnt_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end
  assign timeout_pulse = timeout_pulse_q;
`else
  assign timeout_pulse = 1'b0;
`endif

  assign psel         = (state_q == SETUP) || (state_q == ACCESS);
  assign penable      = (state_q == ACCESS);
  assign cn_ready     = cn_ready_q;
  assign crossbar_sel = crossbar_sel_q;
  assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_cn_apb_sequencer.sv
// Scenario bench for cn_apb_sequencer; expected responses queued at request time, checked on cn_ready.
module tb_cn_apb_sequencer;

  logic       pclk = 1'b0;
  logic       preset_n;
  logic [2:0] rn_valid;
  logic [2:0] cn_ready;
  logic [1:0] crossbar_sel;
  logic       psel, penable, pready, pslverr, rsp_err, timeout_pulse;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] rdy;
    logic       err;
  } exp_t;
  exp_t sb_q[$];

  always #5 pclk = ~pclk;

  cn_apb_sequencer dut (
    .pclk          (pclk),
    .preset_n      (preset_n),
    .rn_valid      (rn_valid),
    .cn_ready      (cn_ready),
    .crossbar_sel  (crossbar_sel),
    .psel          (psel),
    .penable       (penable),
    .pready        (pready),
    .pslverr       (pslverr),
    .rsp_err       (rsp_err),
    .timeout_pulse (timeout_pulse)
  );

  // Scoreboard side: every cn_ready pulse must match the oldest queued expectation.
  always @(negedge pclk) begin
    if (preset_n === 1'b1) begin
      checks++;
      if (psel === 1'b0 && penable !== 1'b0) begin
        errors++;
        $display("FAIL apb_phase: psel=%b penable=%b, required penable=0", psel, penable);
      end
      checks++;
      if ($countones(cn_ready) > 1) begin
        errors++;
        $display("FAIL ready_onehot: cn_ready=%b, required one-hot or zero", cn_ready);
      end
      if (cn_ready !== 3'b000) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready: cn_ready=%b, required none", cn_ready);
        end else begin
          exp_t e;
          logic [1:0] esel;
          e = sb_q.pop_front();
          esel = (e.rdy == 3'b001) ? 2'b01 : (e.rdy == 3'b010) ? 2'b10 : 2'b11;
          if (cn_ready !== e.rdy) begin
            errors++;
            $display("FAIL sb_ready: got %b, required %b", cn_ready, e.rdy);
          end
          checks++;
          if (rsp_err !== e.err) begin
            errors++;
            $display("FAIL sb_rsp_err: got %b, required %b", rsp_err, e.err);
          end
          checks++;
          if (crossbar_sel !== esel) begin
            errors++;
            $display("FAIL sb_sel: got %b, required %b", crossbar_sel, esel);
          end
        end
      end
    end
  end

  task automatic apply_reset;
    @(negedge pclk);
    preset_n = 1'b0;
    rn_valid = 3'b000;
    pready   = 1'b0;
    pslverr  = 1'b0;
    @(negedge pclk);
    preset_n = 1'b1;
  endtask

  // Drives one request, plays the APB completer, and checks ACCESS length and the RESP cycle.
  task automatic run_xfer(input logic [2:0] req, input int waits, input logic err,
                          input logic [2:0] exp_rdy, input logic exp_err, input logic exp_to,
                          input int exp_cyc);
    int   bound;
    int   cyc;
    exp_t e;
    e.rdy = exp_rdy;
    e.err = exp_err;
    @(negedge pclk);
    rn_valid = req;
    pready   = 1'b0;
    pslverr  = 1'b0;
    sb_q.push_back(e);
    bound = 0;
    while (penable !== 1'b1 && bound < 20) begin
      @(negedge pclk);
      bound++;
    end
    cyc = 0;
    while (penable === 1'b1 && cyc < 40) begin
      cyc++;
      if (cyc == waits + 1) begin
        pready  = 1'b1;
        pslverr = err;
      end else begin
        pready  = 1'b0;
        pslverr = 1'b0;
      end
      @(negedge pclk);
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    checks++;
    if (cyc != exp_cyc) begin
      errors++;
      $display("FAIL access_cycles: got %0d, required %0d", cyc, exp_cyc);
    end
    checks++;
    if (psel !== 1'b0 || timeout_pulse !== exp_to) begin
      errors++;
      $display("FAIL resp_phase: psel=%b timeout_pulse=%b, required psel=0 timeout_pulse=%b",
               psel, timeout_pulse, exp_to);
    end
    bound = 0;
    while (cn_ready === 3'b000 && bound < 5) begin
      @(negedge pclk);
      bound++;
    end
    checks++;
    if (cn_ready === 3'b000) begin
      errors++;
      $display("FAIL ready_timeout: cn_ready=%b, required a pulse", cn_ready);
    end
    rn_valid = 3'b000;
    @(negedge pclk);
  endtask

  task automatic test_reset;
    preset_n = 1'b0;
    rn_valid = 3'b000;
    pready   = 1'b0;
    pslverr  = 1'b0;
    #12;
    checks++;
    if ({cn_ready, crossbar_sel, psel, penable, rsp_err, timeout_pulse} !== 9'b0) begin
      errors++;
      $display("FAIL reset_values: cn_ready=%b sel=%b psel=%b penable=%b rsp_err=%b to=%b, required all 0",
               cn_ready, crossbar_sel, psel, penable, rsp_err, timeout_pulse);
    end
    @(negedge pclk);
    preset_n = 1'b1;
  endtask

  task automatic test_single;
    exp_t e;
    e.rdy = 3'b001;
    e.err = 1'b0;
    @(negedge pclk);
    rn_valid = 3'b001;
    pready   = 1'b1;
    sb_q.push_back(e);
    @(posedge pclk); #1;
    checks++;
    if (crossbar_sel !== 2'b01 || psel !== 1'b1 || penable !== 1'b0) begin
      errors++;
      $display("FAIL e0_setup: sel=%b psel=%b penable=%b, required 01 1 0", crossbar_sel, psel, penable);
    end
    @(posedge pclk); #1;
    checks++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      errors++;
      $display("FAIL e1_access: psel=%b penable=%b, required 1 1", psel, penable);
    end
    @(posedge pclk); #1;
    pready = 1'b0;
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || cn_ready !== 3'b000 || crossbar_sel !== 2'b01) begin
      errors++;
      $display("FAIL e2_resp: psel=%b penable=%b cn_ready=%b sel=%b, required 0 0 000 01",
               psel, penable, cn_ready, crossbar_sel);
    end
    @(posedge pclk); #1;
    checks++;
    if (cn_ready !== 3'b001 || crossbar_sel !== 2'b01) begin
      errors++;
      $display("FAIL e3_ready: cn_ready=%b sel=%b, required 001 01", cn_ready, crossbar_sel);
    end
    rn_valid = 3'b000;
    @(posedge pclk); #1;
    checks++;
    if (cn_ready !== 3'b000 || crossbar_sel !== 2'b00) begin
      errors++;
      $display("FAIL e4_idle: cn_ready=%b sel=%b, required 000 00", cn_ready, crossbar_sel);
    end
  endtask

  task automatic test_round_robin;
    int   n;
    int   tp[4];
    exp_t e;
    apply_reset();
    rn_valid = 3'b111;
    pready   = 1'b1;
    e.err = 1'b0;
    e.rdy = 3'b001; sb_q.push_back(e);
    e.rdy = 3'b010; sb_q.push_back(e);
    e.rdy = 3'b100; sb_q.push_back(e);
    e.rdy = 3'b001; sb_q.push_back(e);
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge pclk);
      if (cn_ready !== 3'b000) begin
        tp[n] = c;
        n++;
      end
    end
    rn_valid = 3'b000;
    pready   = 1'b0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL rr_count: got %0d pulses, required 4", n);
    end
    for (int i = 1; i < n; i++) begin
      checks++;
      if (tp[i] - tp[i-1] != 5) begin
        errors++;
        $display("FAIL rr_spacing: got %0d cycles, required 5", tp[i] - tp[i-1]);
      end
    end
    @(negedge pclk);
  endtask

  task automatic test_wait_err;
    run_xfer(3'b010, 3, 1'b1, 3'b010, 1'b1, 1'b0, 4);
    run_xfer(3'b100, 0, 1'b0, 3'b100, 1'b0, 1'b0, 1);
  endtask

  task automatic test_reset_mid;
    int bound;
    @(negedge pclk);
    rn_valid = 3'b011;
    pready   = 1'b0;
    bound = 0;
    while (penable !== 1'b1 && bound < 20) begin
      @(negedge pclk);
      bound++;
    end
    #2 preset_n = 1'b0;
    #1;
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || crossbar_sel !== 2'b00 || cn_ready !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid: psel=%b penable=%b sel=%b cn_ready=%b, required 0 0 00 000",
               psel, penable, crossbar_sel, cn_ready);
    end
    @(negedge pclk);
    preset_n = 1'b1;
    rn_valid = 3'b000;
    run_xfer(3'b011, 0, 1'b0, 3'b001, 1'b0, 1'b0, 1);
  endtask

`ifdef CN_TIMEOUT_EN
  task automatic test_timeout;
    run_xfer(3'b010, -1, 1'b0, 3'b010, 1'b1, 1'b1, 16);
  endtask

  task automatic test_timeout_edge;
    run_xfer(3'b100, 15, 1'b0, 3'b100, 1'b0, 1'b0, 16);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wait_err();
    test_reset_mid();
`ifdef CN_TIMEOUT_EN
    test_timeout();
    test_timeout_edge();
`endif
    repeat (3) @(negedge pclk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses outstanding, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
